// File: rtl/rr_arb2to1_if.sv
// Handshake bundle for the 2:1 round-robin arbiter: two input channels,
// one registered output beat and the downstream mux select.
interface rr_arb2to1_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic [WIDTH-1:0] in0_data_i;
  logic             in0_valid_i;
  logic             in0_ready_o;

  logic [WIDTH-1:0] in1_data_i;
  logic             in1_valid_i;
  logic             in1_ready_o;

  logic [WIDTH-1:0] out_data_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic             sel_o;

  // Arbiter side
  modport slave (
    input  in0_data_i, in0_valid_i,
    input  in1_data_i, in1_valid_i,
    input  out_ready_i,
    output in0_ready_o, in1_ready_o,
    output out_data_o, out_valid_o, sel_o
  );

  // Producer/consumer side
  modport master (
    output in0_data_i, in0_valid_i,
    output in1_data_i, in1_valid_i,
    output out_ready_i,
    input  in0_ready_o, in1_ready_o,
    input  out_data_o, out_valid_o, sel_o
  );

endinterface : rr_arb2to1_if

// File: rtl/rr_arb2to1.sv
// Two-channel round-robin arbiter feeding a single registered output beat.
// Ready outputs are combinational; output valid/data/select are registered.
module rr_arb2to1 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  rr_arb2to1_if.slave  bus
);

  logic [WIDTH-1:0] out_data_q,   out_data_d;
  logic             out_valid_q,  out_valid_d;
  logic             sel_q,        sel_d;
  logic             last_grant_q, last_grant_d;

  logic             ld_c;
  logic             any_valid_c;
  logic             grant_c;
  logic             load_c;

  // Load enable, request detect and round-robin grant
  always_comb begin
    ld_c        = ~out_valid_q | bus.out_ready_i;
    any_valid_c = bus.in0_valid_i | bus.in1_valid_i;
    if (bus.in0_valid_i & bus.in1_valid_i) begin
      grant_c = ~last_grant_q;
    end else begin
      grant_c = bus.in1_valid_i;
    end
    load_c      = ld_c & any_valid_c;
  end

  // Readies are held low while reset is asserted so nothing is accepted then
  assign bus.in0_ready_o = ~rst_i & load_c & ~grant_c;
  assign bus.in1_ready_o = ~rst_i & load_c &  grant_c;

  // Next-state for the output beat and the round-robin pointer
  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    if (load_c) begin
      out_data_d   = grant_c ? bus.in1_data_i : bus.in0_data_i;
      out_valid_d  = 1'b1;
      sel_d        = grant_c;
      last_grant_d = grant_c;
    end else if (ld_c) begin
      out_valid_d  = 1'b0;
    end
  end

  // last_grant resets to 1 so the first contested grant goes to channel 0
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      sel_q        <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.out_data_o  = out_data_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.sel_o       = sel_q;

endmodule : rr_arb2to1

// File: tb/tb_rr_arb2to1.sv
// Directed vector table, reset/contention sequences and a random scoreboard
// run for the 2:1 round-robin arbiter.
module tb_rr_arb2to1;

  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rr_arb2to1_if #(.WIDTH(WIDTH)) bus ();

  rr_arb2to1 #(.WIDTH(WIDTH)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       ordy;
    logic       r0;
    logic       r1;
    logic       ov;
    logic [7:0] od;
    logic       sel;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v0, input logic [7:0] d0, input logic v1,
                              input logic [7:0] d1, input logic ordy, input logic r0,
                              input logic r1, input logic ov, input logic [7:0] od,
                              input logic sel);
    vec_t v;
    v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.ordy = ordy;
    v.r0 = r0; v.r1 = r1; v.ov = ov; v.od = od; v.sel = sel;
    return v;
  endfunction

  task automatic drive(input logic v0, input logic [7:0] d0, input logic v1,
                       input logic [7:0] d1, input logic ordy);
    bus.in0_valid_i = v0;
    bus.in0_data_i  = d0;
    bus.in1_valid_i = v1;
    bus.in1_data_i  = d1;
    bus.out_ready_i = ordy;
  endtask

  vec_t       vecs [17];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  // Reference state for the random run
  logic       m_ov, m_sel, m_last, m_g, m_ld, m_any;
  logic [7:0] m_od, exp_d;
  logic [7:0] seq0, seq1;
  logic       rv0, rv1, rrdy;

  initial begin
    checks = 0;
    errors = 0;

    // v0 d0 v1 d1 ordy | r0 r1 | ov od sel (after edge)
    vecs[0]  = mk(1, 8'h11, 0, 8'h00, 1,  1, 0,  1, 8'h11, 0);
    vecs[1]  = mk(1, 8'h22, 0, 8'h00, 1,  1, 0,  1, 8'h22, 0);
    vecs[2]  = mk(0, 8'h00, 0, 8'h00, 1,  0, 0,  0, 8'h22, 0);
    vecs[3]  = mk(1, 8'hA0, 1, 8'hB0, 1,  0, 1,  1, 8'hB0, 1);
    vecs[4]  = mk(1, 8'hA0, 1, 8'hB0, 1,  1, 0,  1, 8'hA0, 0);
    vecs[5]  = mk(1, 8'hA0, 1, 8'hB0, 1,  0, 1,  1, 8'hB0, 1);
    vecs[6]  = mk(0, 8'h00, 1, 8'h5C, 1,  0, 1,  1, 8'h5C, 1);
    vecs[7]  = mk(1, 8'hA0, 1, 8'hB0, 0,  0, 0,  1, 8'h5C, 1);
    vecs[8]  = mk(1, 8'hA0, 1, 8'hB0, 0,  0, 0,  1, 8'h5C, 1);
    vecs[9]  = mk(1, 8'hA0, 1, 8'hB0, 0,  0, 0,  1, 8'h5C, 1);
    vecs[10] = mk(1, 8'hA0, 1, 8'hB0, 1,  1, 0,  1, 8'hA0, 0);
    vecs[11] = mk(0, 8'h00, 1, 8'h7E, 1,  0, 1,  1, 8'h7E, 1);
    vecs[12] = mk(0, 8'h00, 0, 8'h00, 1,  0, 0,  0, 8'h7E, 1);
    vecs[13] = mk(0, 8'h00, 0, 8'h00, 1,  0, 0,  0, 8'h7E, 1);
    vecs[14] = mk(1, 8'h3C, 0, 8'h00, 0,  1, 0,  1, 8'h3C, 0);
    vecs[15] = mk(1, 8'h44, 0, 8'h00, 0,  0, 0,  1, 8'h3C, 0);
    vecs[16] = mk(1, 8'h44, 1, 8'h55, 1,  0, 1,  1, 8'h55, 1);

    // Reset state with requests pending
    rst = 1'b1;
    drive(1, 8'hAA, 1, 8'hBB, 1);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("rst_out_data",  32'(bus.out_data_o),  32'd0);
    chk("rst_sel",       32'(bus.sel_o),       32'd0);
    chk("rst_ready0",    32'(bus.in0_ready_o), 32'd0);
    chk("rst_ready1",    32'(bus.in1_ready_o), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, vecs[i].ordy);
      #2;
      chk($sformatf("vec%0d_ready0", i), 32'(bus.in0_ready_o), 32'(vecs[i].r0));
      chk($sformatf("vec%0d_ready1", i), 32'(bus.in1_ready_o), 32'(vecs[i].r1));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid_o), 32'(vecs[i].ov));
      chk($sformatf("vec%0d_data", i),  32'(bus.out_data_o),  32'(vecs[i].od));
      chk($sformatf("vec%0d_sel", i),   32'(bus.sel_o),       32'(vecs[i].sel));
    end

    // Reset between edges while a beat (0x55, sel 1) is held
    drive(1, 8'h66, 0, 8'h00, 0);
    rst = 1'b1;
    #1;
    chk("midrst_valid",  32'(bus.out_valid_o), 32'd0);
    chk("midrst_data",   32'(bus.out_data_o),  32'd0);
    chk("midrst_sel",    32'(bus.sel_o),       32'd0);
    chk("midrst_ready0", 32'(bus.in0_ready_o), 32'd0);
    chk("midrst_ready1", 32'(bus.in1_ready_o), 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_hold_valid", 32'(bus.out_valid_o), 32'd0);
    rst = 1'b0;
    drive(0, 8'h00, 0, 8'h00, 1);
    @(posedge clk);
    #1;
    chk("postrst_valid", 32'(bus.out_valid_o), 32'd0);

    // Contention from reset: alternation starts with channel 0
    drive(1, 8'hA0, 1, 8'hB0, 1);
    for (int i = 0; i < 6; i++) begin
      #2;
      chk($sformatf("cont%0d_ready0", i), 32'(bus.in0_ready_o), 32'((i % 2) == 0));
      chk($sformatf("cont%0d_ready1", i), 32'(bus.in1_ready_o), 32'((i % 2) == 1));
      @(posedge clk);
      #1;
      chk($sformatf("cont%0d_data", i), 32'(bus.out_data_o), ((i % 2) == 0) ? 32'hA0 : 32'hB0);
      chk($sformatf("cont%0d_sel", i),  32'(bus.sel_o),      32'(i % 2));
    end

    // Random run against a reference model and per-channel scoreboards
    rst = 1'b1;
    drive(0, 8'h00, 0, 8'h00, 0);
    #1;
    rst = 1'b0;
    m_ov = 1'b0; m_od = 8'h00; m_sel = 1'b0; m_last = 1'b1;
    seq0 = 8'h00; seq1 = 8'h80;
    for (int c = 0; c < 10000; c++) begin
      rv0  = ($urandom_range(0, 9) < 6);
      rv1  = ($urandom_range(0, 9) < 6);
      rrdy = ($urandom_range(0, 9) < 7);
      drive(rv0, seq0, rv1, seq1, rrdy);
      #2;
      m_ld  = !m_ov || rrdy;
      m_any = rv0 || rv1;
      m_g   = (rv0 && rv1) ? !m_last : rv1;
      if (bus.in0_ready_o !== (m_ld && m_any && !m_g) ||
          bus.in1_ready_o !== (m_ld && m_any && m_g)) begin
        chk("rnd_ready", {30'd0, bus.in1_ready_o, bus.in0_ready_o},
            {30'd0, m_ld && m_any && m_g, m_ld && m_any && !m_g});
      end else begin
        checks++;
      end
      if (bus.in0_ready_o && bus.in1_ready_o)
        chk("rnd_both_ready", 32'd1, 32'd0);
      // Output transfer pops the scoreboard of the held beat's channel
      if (m_ov && rrdy) begin
        if (m_sel ? (q1.size() == 0) : (q0.size() == 0)) begin
          chk("rnd_sb_empty", 32'(m_sel), 32'hFFFF);
        end else begin
          exp_d = m_sel ? q1.pop_front() : q0.pop_front();
          chk("rnd_sb_data", 32'(bus.out_data_o), 32'(exp_d));
        end
      end
      if (bus.in0_ready_o) begin q0.push_back(seq0); seq0 = seq0 + 8'd1; end
      if (bus.in1_ready_o) begin q1.push_back(seq1); seq1 = seq1 + 8'd1; end
      if (m_ld && m_any) begin
        m_ov = 1'b1; m_od = m_g ? bus.in1_data_i : bus.in0_data_i;
        m_sel = m_g; m_last = m_g;
      end else if (m_ld) begin
        m_ov = 1'b0;
      end
      @(posedge clk);
      #1;
      if (bus.out_valid_o !== m_ov || bus.sel_o !== m_sel || bus.out_data_o !== m_od) begin
        chk("rnd_out", {22'd0, bus.out_valid_o, bus.sel_o, bus.out_data_o},
            {22'd0, m_ov, m_sel, m_od});
      end else begin
        checks++;
      end
    end

    // Drain: nothing may be left behind or duplicated
    drive(0, 8'h00, 0, 8'h00, 1);
    for (int c = 0; c < 4; c++) begin
      #2;
      if (m_ov) begin
        if (m_sel ? (q1.size() == 0) : (q0.size() == 0)) begin
          chk("drain_sb_empty", 32'(m_sel), 32'hFFFF);
        end else begin
          exp_d = m_sel ? q1.pop_front() : q0.pop_front();
          chk("drain_sb_data", 32'(bus.out_data_o), 32'(exp_d));
        end
      end
      m_ov = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("drain_valid", 32'(bus.out_valid_o), 32'd0);
    chk("drain_q0",    32'(q0.size()),       32'd0);
    chk("drain_q1",    32'(q1.size()),       32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_rr_arb2to1

// File: doc/rr_arb2to1.md
RR_ARB2TO1 -- requirements
Module: rr_arb2to1

Interface
REQ-001 Parameter: WIDTH, default 8, data width of each input channel and of the output.
REQ-002 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 in0_data_i  input  WIDTH  channel 0 data.
REQ-005 in0_valid_i  input  1  channel 0 has a beat.
REQ-006 in0_ready_o  output  1  channel 0 beat accepted this cycle.
REQ-007 in1_data_i  input  WIDTH  channel 1 data.
REQ-008 in1_valid_i  input  1  channel 1 has a beat.
REQ-009 in1_ready_o  output  1  channel 1 beat accepted this cycle.
REQ-010 out_data_o  output  WIDTH  registered output beat.
REQ-011 out_valid_o  output  1  out_data_o holds a valid beat.
REQ-012 out_ready_i  input  1  downstream accepts the beat.
REQ-013 sel_o  output  1  source channel of the held beat; drives the select of the downstream 2:1 mux (0 = channel 0, 1 = channel 1).

Function
REQ-014 The block SHALL hold one output beat in a register (out_data_o, out_valid_o, sel_o); transfer out = out_valid_o & out_ready_i.
REQ-015 Load enable ld = ~out_valid_o | out_ready_i; a new beat SHALL load only when ld = 1 and at least one input is valid.
REQ-016 Arbitration SHALL be round-robin using a 1-bit last_grant register: only one valid -> grant it; both valid -> grant ~last_grant.
REQ-017 inN_ready_o SHALL be combinational: high only for the granted channel, only when ld = 1; never both high in the same cycle.
REQ-018 On a load the block SHALL register the granted data into out_data_o, the granted index into sel_o and into last_grant, and set out_valid_o = 1; latency input accept -> out_valid_o = 1 cycle.
REQ-019 ld = 1 with no input valid SHALL clear out_valid_o; out_data_o, sel_o and last_grant SHALL hold.
REQ-020 ld = 0 (out_valid_o = 1, out_ready_i = 0) SHALL hold out_data_o, sel_o, out_valid_o stable, deassert both inN_ready_o, and leave last_grant unchanged.
REQ-021 Simultaneous output transfer and input accept in one cycle SHALL sustain throughput of one beat per cycle with no bubble.
REQ-022 With both inputs continuously valid and out_ready_i = 1, grants SHALL strictly alternate 0,1,0,1...
REQ-023 Input data SHALL not be modified; out_data_o equals the accepted inN_data_i bit-for-bit.
REQ-024 out_valid_o SHALL not depend combinationally on any input; ready outputs may depend combinationally on valids and out_ready_i.

Reset
REQ-025 While rst_i = 1: out_valid_o = 0, out_data_o = 0, sel_o = 0, last_grant = 1 (first contested grant goes to channel 0), in0_ready_o = in1_ready_o = 0.
REQ-026 Reset asserted mid-operation SHALL discard any held beat immediately without waiting for a clock edge; no beat is presented after release until a new input is accepted.
REQ-027 First rising edge after rst_i falls SHALL be a normal operating cycle.

Verification
REQ-028 Reset: assert rst_i between clock edges with out_valid_o = 1 -> out_valid_o, out_data_o, sel_o go 0 at once; both ready_o = 0.
REQ-029 Single source: in0 beats 0x11,0x22 back-to-back, out_ready_i = 1 -> out_data_o 0x11 then 0x22 on consecutive cycles, sel_o = 0, in1_ready_o never 1.
REQ-030 Contention: both valid from reset, in0 = 0xA0, in1 = 0xB0 held, out_ready_i = 1 -> outputs 0xA0, 0xB0, 0xA0, 0xB0..., sel_o 0,1,0,1.
REQ-031 Backpressure: out holds 0x5C (sel_o = 1), out_ready_i = 0 for 3 cycles with both inputs valid -> out_data_o/sel_o stable, both ready_o = 0, next grant after release goes to channel 0.
REQ-032 Drain: single beat 0x7E on in1, then no valids, out_ready_i = 1 -> out_valid_o high 1 cycle, then 0; sel_o remains 1.
REQ-033 Random: random valids/ready over 10,000 cycles, WIDTH = 8 -> scoreboard per-channel order preserved, no loss or duplication, ready_o never both high.
